// File: rtl/sign_ext.sv
// Two's-complement sign extender, N -> M bits, with combinational and registered outputs.
// Behavioral and structural extensions are built side by side and compared for o_mismatch.

module sign_ext_behavioral #(
  parameter int unsigned N = 12,
  parameter int unsigned M = 32
) (
  input  logic [N-1:0] data_i,
  output logic [M-1:0] data_o
);

  assign data_o = M'(signed'(data_i));

endmodule

module sign_ext_structural #(
  parameter int unsigned N = 12,
  parameter int unsigned M = 32
) (
  input  logic [N-1:0] data_i,
  output logic [M-1:0] data_o
);

  // Pure wiring: low bits pass through, upper bits copy the sign bit.
  for (genvar k = 0; k < M; k++) begin : g_bit
    if (k < N) begin : g_pass
      assign data_o[k] = data_i[k];
    end else begin : g_sign
      assign data_o[k] = data_i[N-1];
    end
  end

endmodule

module sign_ext #(
  parameter int unsigned N = 12,
  parameter int unsigned M = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_data,
  input  logic         i_valid,
  output logic [M-1:0] o_data,
  output logic [M-1:0] o_data_q,
  output logic         o_valid,
  output logic         o_mismatch
);

  if (N < 1 || M < N) begin : g_bad_param
    $fatal(1, "sign_ext: illegal widths N=%0d M=%0d", N, M);
  end

  logic [M-1:0] beh_data;
  logic [M-1:0] str_data;

  sign_ext_behavioral #(
    .N(N),
    .M(M)
  ) u_beh (
    .data_i(i_data),
    .data_o(beh_data)
  );

  sign_ext_structural #(
    .N(N),
    .M(M)
  ) u_str (
    .data_i(i_data),
    .data_o(str_data)
  );

  assign o_data     = beh_data;
  assign o_mismatch = (beh_data != str_data);

  logic [M-1:0] data_d, data_q;
  logic         valid_d, valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = i_valid;
    if (i_valid) begin
      data_d = beh_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign o_data_q = data_q;
  assign o_valid  = valid_q;

endmodule

// File: tb/tb_sign_ext.sv
// Bench for sign_ext: table-driven combinational vectors over four width configurations,
// random sweeps against an arithmetic model, and a scoreboarded registered-path sequence.

module tb_sign_ext;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic [11:0] d12 = '0;
  logic [19:0] d20 = '0;
  logic [7:0]  d8  = '0;
  logic [0:0]  d1  = '0;

  logic [31:0] o12, o12_q, o20, o20_q;
  logic [7:0]  o8, o8_q;
  logic [3:0]  o1, o1_q;
  logic        v12, v20, v8, v1;
  logic        mm12, mm20, mm8, mm1;

  sign_ext #(.N(12), .M(32)) dut12 (
    .i_clk(clk), .i_rst(rst), .i_data(d12), .i_valid(vld),
    .o_data(o12), .o_data_q(o12_q), .o_valid(v12), .o_mismatch(mm12)
  );
  sign_ext #(.N(20), .M(32)) dut20 (
    .i_clk(clk), .i_rst(rst), .i_data(d20), .i_valid(vld),
    .o_data(o20), .o_data_q(o20_q), .o_valid(v20), .o_mismatch(mm20)
  );
  sign_ext #(.N(8), .M(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_data(d8), .i_valid(vld),
    .o_data(o8), .o_data_q(o8_q), .o_valid(v8), .o_mismatch(mm8)
  );
  sign_ext #(.N(1), .M(4)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_data(d1), .i_valid(vld),
    .o_data(o1), .o_data_q(o1_q), .o_valid(v1), .o_mismatch(mm1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int cfg_n(input int cfg);
    case (cfg)
      0: return 12;
      1: return 20;
      2: return 8;
      default: return 1;
    endcase
  endfunction

  function automatic int cfg_m(input int cfg);
    case (cfg)
      0, 1: return 32;
      2: return 8;
      default: return 4;
    endcase
  endfunction

  // Arithmetic reference: interpret din as n-bit signed, then wrap to m bits.
  function automatic logic [31:0] model(input int cfg, input logic [31:0] din);
    longint unsigned mask_n, mask_m, val;
    int n, m;
    n = cfg_n(cfg);
    m = cfg_m(cfg);
    mask_n = (64'd1 << n) - 64'd1;
    mask_m = (64'd1 << m) - 64'd1;
    val = longint'(din) & mask_n;
    if (((val >> (n - 1)) & 64'd1) == 64'd1) val = val - (64'd1 << n);
    return 32'(val & mask_m);
  endfunction

  task automatic apply(input int cfg, input logic [31:0] din,
                       output logic [31:0] dout, output logic mm);
    case (cfg)
      0: d12 = din[11:0];
      1: d20 = din[19:0];
      2: d8  = din[7:0];
      default: d1 = din[0:0];
    endcase
    #10;
    case (cfg)
      0: begin dout = o12;        mm = mm12; end
      1: begin dout = o20;        mm = mm20; end
      2: begin dout = 32'(o8);    mm = mm8;  end
      default: begin dout = 32'(o1); mm = mm1; end
    endcase
  endtask

  typedef struct {
    int          cfg;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  typedef struct {
    logic [31:0] data;
    logic        valid;
  } reg_exp_t;

  reg_exp_t    sb_q[$];
  logic [31:0] m_data = '0;
  logic        m_valid = 1'b0;

  // One registered-path cycle on the 12->32 instance, scoreboarded.
  task automatic step(input logic r, input logic v, input logic [11:0] d);
    reg_exp_t e;
    @(negedge clk);
    rst = r;
    vld = v;
    d12 = d;
    if (r) begin
      m_data  = '0;
      m_valid = 1'b0;
    end else begin
      m_valid = v;
      if (v) m_data = model(0, 32'(d));
    end
    sb_q.push_back('{data: m_data, valid: m_valid});
    @(posedge clk);
    #1;
    check("comb_during_seq", o12, model(0, 32'(d)));
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected at least 1");
    end else begin
      e = sb_q.pop_front();
      check("reg_data_q", o12_q, e.data);
      check("reg_valid", 32'(v12), 32'(e.valid));
    end
  endtask

  initial begin
    logic [31:0] dout;
    logic        mm;
    logic [31:0] rnd;

    vecs[0]  = '{0, 32'h000, 32'h0000_0000};
    vecs[1]  = '{0, 32'h7FF, 32'h0000_07FF};
    vecs[2]  = '{0, 32'h800, 32'hFFFF_F800};
    vecs[3]  = '{0, 32'hFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{0, 32'h001, 32'h0000_0001};
    vecs[5]  = '{1, 32'h00000, 32'h0000_0000};
    vecs[6]  = '{1, 32'h7FFFF, 32'h0007_FFFF};
    vecs[7]  = '{1, 32'h80000, 32'hFFF8_0000};
    vecs[8]  = '{1, 32'hFFFFF, 32'hFFFF_FFFF};
    vecs[9]  = '{2, 32'h80, 32'h0000_0080};
    vecs[10] = '{2, 32'h7F, 32'h0000_007F};
    vecs[11] = '{3, 32'h1, 32'h0000_000F};
    vecs[12] = '{3, 32'h0, 32'h0000_0000};

    // Reset held for two edges: all registered outputs cleared.
    repeat (2) @(posedge clk);
    #1;
    check("rst_q12", o12_q, 32'h0);
    check("rst_v12", 32'(v12), 32'h0);
    check("rst_q20", o20_q, 32'h0);
    check("rst_v20", 32'(v20), 32'h0);
    check("rst_q8", 32'(o8_q), 32'h0);
    check("rst_v8", 32'(v8), 32'h0);
    check("rst_q1", 32'(o1_q), 32'h0);
    check("rst_v1", 32'(v1), 32'h0);

    foreach (vecs[i]) begin
      apply(vecs[i].cfg, vecs[i].din, dout, mm);
      check($sformatf("vec%0d_data", i), dout, vecs[i].exp);
      check($sformatf("vec%0d_mismatch", i), 32'(mm), 32'h0);
    end

    for (int cfg = 0; cfg < 4; cfg++) begin
      for (int i = 0; i < 100; i++) begin
        rnd = $urandom;
        apply(cfg, rnd, dout, mm);
        check($sformatf("rand_cfg%0d_data", cfg), dout, model(cfg, rnd));
        check($sformatf("rand_cfg%0d_mismatch", cfg), 32'(mm), 32'h0);
      end
    end

    step(1'b1, 1'b0, 12'h000);
    step(1'b1, 1'b0, 12'h000);
    step(1'b0, 1'b1, 12'h800);
    step(1'b0, 1'b1, 12'h123);
    step(1'b0, 1'b0, 12'h555);
    step(1'b0, 1'b0, 12'h0AA);
    step(1'b0, 1'b1, 12'h7FF);
    step(1'b1, 1'b1, 12'hABC);
    step(1'b0, 1'b1, 12'h001);
    for (int i = 0; i < 20; i++) begin
      rnd = $urandom;
      step(1'b0, rnd[12], rnd[11:0]);
    end
    step(1'b1, 1'b1, 12'hFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
